// File: rtl/prog_loader_if.sv
// Memory write port of the boot loader: word write request held until accepted.
// Master drives request/address/data; slave answers with ready in the same cycle.
interface prog_loader_if;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ready_i;

    modport master (
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_ready_i
    );

    modport slave (
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_ready_i
    );
endinterface

// File: rtl/prog_loader.sv
// UART boot loader: magic A5 5A C3 3C, 4-byte LE length, LE words written to memory.
// Write request rises 1 cycle after the 4th data byte and is held until mem_ready_i.
module prog_loader #(
    parameter int          BAUD_DIV       = 434,
    parameter logic [31:0] BASE_ADDR      = 32'h4000_0000,
    parameter int          TIMEOUT_CYCLES = 5_000_000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         program_rx_i,
    output logic         prog_mode_o,
    output logic         core_rst_o,
    output logic         done_o,
    output logic         err_o,
    prog_loader_if.master mem
);
    localparam int          CW    = $clog2(BAUD_DIV);
    localparam int          TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] MAGIC = 32'hA55A_C33C;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {L_IDLE, L_LEN, L_DATA, L_WRITE, L_FIN} ld_state_e;

    // ---------------- UART receiver ----------------
    rx_state_e   rx_state_q, rx_state_d;
    logic [2:0]  sync_q, sync_d;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        byte_vld_q, byte_vld_d;
    logic        frame_err_q, frame_err_d;
    logic        rx_s, rx_prev;

    // sync_q[1] is the synchronised line, sync_q[2] its previous value for edge detect
    assign rx_s    = sync_q[1];
    assign rx_prev = sync_q[2];

    always_comb begin
        sync_d      = {sync_q[1:0], program_rx_i};
        rx_state_d  = rx_state_q;
        baud_cnt_d  = baud_cnt_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        byte_vld_d  = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                baud_cnt_d = '0;
                if (!rx_s && rx_prev) rx_state_d = RX_START;
            end
            RX_START: begin
                if (baud_cnt_q == CW'(BAUD_DIV / 2 - 1)) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (baud_cnt_q == CW'(BAUD_DIV - 1)) begin
                    baud_cnt_d = '0;
                    shreg_d    = {rx_s, shreg_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (baud_cnt_q == CW'(BAUD_DIV - 1)) begin
                    rx_state_d  = RX_IDLE;
                    byte_vld_d  = rx_s;
                    frame_err_d = !rx_s;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_state_q  <= RX_IDLE;
            sync_q      <= 3'b111;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            sync_q      <= sync_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            byte_vld_q  <= byte_vld_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ---------------- Loader FSM ----------------
    ld_state_e   state_q, state_d;
    logic [23:0] win_q, win_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [31:0] asm_q, asm_d;
    logic [29:0] words_q, words_d;
    logic [29:0] idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        prog_mode_q, prog_mode_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] next_asm;
    logic        tmo_hit;

    assign tmo_hit = (tmo_q >= TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        // Length and data words share one little-endian byte-lane assembler
        next_asm = asm_q;
        next_asm[{bcnt_q, 3'b000} +: 8] = shreg_q;

        state_d     = state_q;
        win_d       = win_q;
        bcnt_d      = bcnt_q;
        asm_d       = asm_q;
        words_d     = words_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        prog_mode_d = prog_mode_q;
        done_d      = 1'b0;
        err_d       = err_q | frame_err_q;

        case (state_q)
            L_IDLE: begin
                if (byte_vld_q) begin
                    win_d = {win_q[15:0], shreg_q};
                    if ({win_q, shreg_q} == MAGIC) begin
                        state_d     = L_LEN;
                        prog_mode_d = 1'b1;
                        err_d       = 1'b0;
                        win_d       = '0;
                        idx_d       = '0;
                        bcnt_d      = '0;
                        tmo_d       = TW'(1);
                    end
                end
            end
            L_LEN, L_DATA: begin
                if (byte_vld_q) begin
                    asm_d  = next_asm;
                    bcnt_d = bcnt_q + 2'd1;
                    tmo_d  = TW'(1);
                    if (bcnt_q == 2'd3) begin
                        if (state_q == L_LEN) begin
                            // Byte count truncated to whole words
                            words_d = next_asm[31:2];
                            if (next_asm[31:2] == '0) begin
                                state_d     = L_FIN;
                                done_d      = 1'b1;
                                prog_mode_d = 1'b0;
                            end else begin
                                state_d = L_DATA;
                            end
                        end else begin
                            state_d     = L_WRITE;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = BASE_ADDR + {idx_q, 2'b00};
                            mem_wdata_d = next_asm;
                        end
                    end
                end else if (tmo_hit) begin
                    state_d     = L_IDLE;
                    prog_mode_d = 1'b0;
                    err_d       = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            L_WRITE: begin
                if (byte_vld_q) err_d = 1'b1;
                if (mem.mem_ready_i) begin
                    mem_we_d = 1'b0;
                    idx_d    = idx_q + 1'b1;
                    words_d  = words_q - 1'b1;
                    if (words_q == 30'd1) begin
                        state_d     = L_FIN;
                        done_d      = 1'b1;
                        prog_mode_d = 1'b0;
                    end else begin
                        state_d = L_DATA;
                    end
                end
            end
            L_FIN:   state_d = L_IDLE;
            default: state_d = L_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= L_IDLE;
            win_q       <= '0;
            bcnt_q      <= '0;
            asm_q       <= '0;
            words_q     <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            prog_mode_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            bcnt_q      <= bcnt_d;
            asm_q       <= asm_d;
            words_q     <= words_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            prog_mode_q <= prog_mode_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign prog_mode_o     = prog_mode_q;
    assign core_rst_o      = prog_mode_q;
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign mem.mem_we_o    = mem_we_q;
    assign mem.mem_addr_o  = mem_addr_q;
    assign mem.mem_wdata_o = mem_wdata_q;
endmodule
